// File: rtl/attempt_guard.sv
// Attempt guard: turns PIN-checker verdicts into access grants, timed lockouts
// and sticky card retention, and gates new PIN entry through pin_enable.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ARMED    | idle, accepting verdicts, counting consecutive failures
// GRANT    | access_granted high, timer counting the grant window down
// LOCKED   | lockout in progress, timer counting the lockout down
// RETAINED | card kept; only reset leaves this state
module attempt_guard #(
  parameter int MAX_TRIES    = 3,
  parameter int MAX_LOCKOUTS = 2,
  parameter int LOCK_CYCLES  = 1000,
  parameter int GRANT_CYCLES = 100,
  parameter int LW           = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          correct,
  input  logic          incorrect,
  output logic          pin_enable,
  output logic          access_granted,
  output logic          locked,
  output logic          card_retained,
  output logic [1:0]    fail_count,
  output logic [LW-1:0] lock_remaining,
  output logic          verdict_err
);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    GRANT    = 2'd1,
    LOCKED   = 2'd2,
    RETAINED = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [LW-1:0] timer, timer_nx;
  logic [1:0]    fail_cnt, fail_nx;
  logic [1:0]    lock_cnt, lock_nx;
  logic [1:0]    fail_inc, lock_inc;
  logic          err_q, err_nx;
  logic          correct_q, incorrect_q;
  logic          ev_ok, ev_bad;

  assign ev_ok    = correct & ~correct_q;
  assign ev_bad   = incorrect & ~incorrect_q;
  assign fail_inc = fail_cnt + 2'd1;
  assign lock_inc = lock_cnt + 2'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ARMED;
      timer       <= '0;
      fail_cnt    <= 2'd0;
      lock_cnt    <= 2'd0;
      err_q       <= 1'b0;
      // edge registers start high so a level held across reset is not an event
      correct_q   <= 1'b1;
      incorrect_q <= 1'b1;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      fail_cnt    <= fail_nx;
      lock_cnt    <= lock_nx;
      err_q       <= err_nx;
      correct_q   <= correct;
      incorrect_q <= incorrect;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    fail_nx  = fail_cnt;
    lock_nx  = lock_cnt;
    err_nx   = 1'b0;
    case (state)
      ARMED: begin
        if (ev_bad) begin
          err_nx = ev_ok;
          if (fail_inc == 2'(MAX_TRIES)) begin
            fail_nx = 2'd0;
            if (lock_inc == 2'(MAX_LOCKOUTS)) begin
              state_nx = RETAINED;
            end else begin
              state_nx = LOCKED;
              timer_nx = LW'(LOCK_CYCLES - 1);
              lock_nx  = lock_inc;
            end
          end else begin
            fail_nx = fail_inc;
          end
        end else if (ev_ok) begin
          state_nx = GRANT;
          timer_nx = LW'(GRANT_CYCLES - 1);
          fail_nx  = 2'd0;
          lock_nx  = 2'd0;
        end
      end
      GRANT, LOCKED: begin
        if (timer == '0) begin
          state_nx = ARMED;
        end else begin
          timer_nx = timer - LW'(1);
        end
      end
      RETAINED: begin
        state_nx = RETAINED;
      end
      default: begin
        state_nx = ARMED;
        timer_nx = '0;
        fail_nx  = 2'd0;
        lock_nx  = 2'd0;
      end
    endcase
  end

  assign pin_enable     = (state == ARMED);
  assign access_granted = (state == GRANT);
  assign locked         = (state == LOCKED);
  assign card_retained  = (state == RETAINED);
  assign fail_count     = fail_cnt;
  assign lock_remaining = (state == LOCKED) ? timer + LW'(1) : '0;
  assign verdict_err    = err_q;

endmodule

// File: tb/tb_attempt_guard.sv
// Directed bench for attempt_guard: expected values are queued as stimulus is
// driven and popped against DUT outputs one cycle later.
module tb_attempt_guard;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          correct = 1'b0;
  logic          incorrect = 1'b0;
  logic          pin_enable;
  logic          access_granted;
  logic          locked;
  logic          card_retained;
  logic [1:0]    fail_count;
  logic [LW-1:0] lock_remaining;
  logic          verdict_err;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int cnt;
  int last;

  attempt_guard #(
    .MAX_TRIES(3), .MAX_LOCKOUTS(2), .LOCK_CYCLES(1000), .GRANT_CYCLES(100), .LW(LW)
  ) dut (
    .clk(clk), .reset(reset), .correct(correct), .incorrect(incorrect),
    .pin_enable(pin_enable), .access_granted(access_granted), .locked(locked),
    .card_retained(card_retained), .fail_count(fail_count),
    .lock_remaining(lock_remaining), .verdict_err(verdict_err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input int observed);
    int expected;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: observed=%0d expected=<none queued>", tag, observed);
    end else begin
      expected = exp_q.pop_front();
      assert (observed === expected) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  // one rising verdict: the step after the rise is where outputs first react
  task automatic bad_pulse();
    incorrect = 1'b1;
    step(2);
    incorrect = 1'b0;
    step(2);
  endtask

  task automatic wait_idle(input string tag);
    cnt = 0;
    while (!pin_enable && cnt < 3000) begin
      step(1);
      cnt++;
    end
    push(1);
    check(tag, int'(pin_enable));
  endtask

  initial begin
    // reset state
    do_reset();
    push(1); push(0); push(0); push(0); push(0); push(0); push(0);
    check("rst_pin_enable", int'(pin_enable));
    check("rst_access_granted", int'(access_granted));
    check("rst_locked", int'(locked));
    check("rst_card_retained", int'(card_retained));
    check("rst_fail_count", int'(fail_count));
    check("rst_lock_remaining", int'(lock_remaining));
    check("rst_verdict_err", int'(verdict_err));

    // correct pulse of 3 cycles -> 100-cycle grant
    correct = 1'b1;
    push(1); push(0); push(0);
    step(1);
    check("grant_first", int'(access_granted));
    check("grant_pin_enable", int'(pin_enable));
    check("grant_fail_count", int'(fail_count));
    cnt = 0;
    push(100); push(1);
    while (access_granted && cnt < 2000) begin
      cnt++;
      if (cnt == 3) correct = 1'b0;
      step(1);
    end
    check("grant_length", cnt);
    check("grant_pin_enable_after", int'(pin_enable));

    // incorrect, incorrect, correct
    push(1); bad_pulse(); check("fail_count_1", int'(fail_count));
    push(2); bad_pulse(); check("fail_count_2", int'(fail_count));
    correct = 1'b1;
    push(0); push(1);
    step(1);
    check("fail_count_cleared", int'(fail_count));
    check("grant_after_fails", int'(access_granted));
    step(1);
    correct = 1'b0;
    wait_idle("grant2_end");

    // simultaneous rise
    correct = 1'b1; incorrect = 1'b1;
    push(1); push(1); push(0);
    step(1);
    check("verdict_err_pulse", int'(verdict_err));
    check("verdict_err_fail_count", int'(fail_count));
    check("verdict_err_no_grant", int'(access_granted));
    push(0);
    step(1);
    check("verdict_err_one_cycle", int'(verdict_err));
    correct = 1'b0; incorrect = 1'b0;
    step(2);
    do_reset();

    // three failures -> full lockout, extra verdicts during it ignored
    bad_pulse(); bad_pulse();
    incorrect = 1'b1;
    push(1); push(1000); push(0); push(0);
    step(1);
    check("lock_first", int'(locked));
    check("lock_remaining_first", int'(lock_remaining));
    check("lock_fail_count", int'(fail_count));
    check("lock_pin_enable", int'(pin_enable));
    cnt = 0; last = 0;
    push(0); push(0);
    while (locked && cnt < 5000) begin
      last = int'(lock_remaining);
      cnt++;
      if (cnt == 2) incorrect = 1'b0;
      if (cnt == 4) incorrect = 1'b1;
      if (cnt == 6) begin
        incorrect = 1'b0;
        check("lock_extra_fail_count", int'(fail_count));
        check("lock_extra_verdict_err", int'(verdict_err));
      end
      step(1);
    end
    push(1000); push(1); push(0); push(1);
    check("lock_length", cnt);
    check("lock_remaining_last", last);
    check("lock_remaining_after", int'(lock_remaining));
    check("lock_pin_enable_after", int'(pin_enable));

    // two failures then correct clear the lockout history
    bad_pulse(); bad_pulse();
    correct = 1'b1;
    push(1);
    step(1);
    check("grant_clears_history", int'(access_granted));
    correct = 1'b0;
    wait_idle("grant3_end");

    bad_pulse(); bad_pulse();
    incorrect = 1'b1;
    push(1); push(0);
    step(1);
    check("relock_locked", int'(locked));
    check("relock_not_retained", int'(card_retained));
    incorrect = 1'b0;
    wait_idle("relock_end");

    // second lockout's worth of failures -> retention
    bad_pulse(); bad_pulse();
    incorrect = 1'b1;
    push(1); push(0); push(0);
    step(1);
    check("retained", int'(card_retained));
    check("retained_locked", int'(locked));
    check("retained_pin_enable", int'(pin_enable));
    incorrect = 1'b0;
    step(2);
    correct = 1'b1;
    push(0); push(1);
    step(2);
    check("retained_no_grant", int'(access_granted));
    check("retained_sticky", int'(card_retained));
    correct = 1'b0;
    step(1);
    do_reset();
    push(0); push(1);
    check("retained_cleared", int'(card_retained));
    check("retained_reset_pin_enable", int'(pin_enable));

    // reset in the middle of a lockout with incorrect held across release
    bad_pulse(); bad_pulse();
    incorrect = 1'b1;
    step(1);
    incorrect = 1'b0;
    cnt = 1;
    while (locked && cnt < 500) begin
      step(1);
      cnt++;
    end
    incorrect = 1'b1;
    reset = 1'b0;
    push(0); push(0); push(0); push(1);
    step(1);
    check("midlock_locked", int'(locked));
    check("midlock_lock_remaining", int'(lock_remaining));
    check("midlock_fail_count", int'(fail_count));
    check("midlock_pin_enable", int'(pin_enable));
    reset = 1'b1;
    push(0); push(0); push(1);
    step(3);
    check("held_level_no_event", int'(fail_count));
    check("held_level_no_lock", int'(locked));
    check("held_level_pin_enable", int'(pin_enable));
    incorrect = 1'b0;
    step(1);
    push(1);
    bad_pulse();
    check("post_reset_event", int'(fail_count));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
